// File: rtl/if_stage_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// The optional interrupt tag is enabled by defining IF_INT_TAG_EN.
package if_stage_pkg;

  localparam int          IF_TO_ID_BUS_WIDTH = 65;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] pc;
    logic        int_flag;
  } if_to_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_next_mux.sv
// Next fetch-PC selection: trap redirect, then branch, then sequential.
// Purely combinational; reset is applied by the registers in if_stage.
module pc_next_mux
  import if_stage_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        fire_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        int_assert_i,
  input  logic [31:0] int_addr_i,
  output logic [31:0] pc_next_o
);

  // Trap and branch may coincide, so this must stay a priority chain.
  always_comb begin
    pc_next_o = pc_i;
    priority case (1'b1)
      int_assert_i: pc_next_o = word_align(int_addr_i);
      br_taken_i:   pc_next_o = word_align(br_target_i);
      fire_i:       pc_next_o = pc_i + 32'd4;
      default:      pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, ROM address, redirects, IF->ID handover.
// Define IF_INT_TAG_EN to tag one handed-over instruction per pending interrupt.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          br_taken,
  input  logic [31:0]                   br_target,
  input  logic                          int_assert,
  input  logic [31:0]                   int_addr,
  input  logic                          int_req,
  input  logic                          hold_flag_if,
  input  logic                          id_allow_in,
  output logic [31:0]                   irom_addr,
  output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
  output logic                          if_to_id_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        kill, fire, int_flag;
  if_to_id_t   bus_s;

  assign kill           = br_taken | int_assert;
  assign if_to_id_valid = if_valid_q & ~kill & ~hold_flag_if;
  assign fire           = if_to_id_valid & id_allow_in;

  // ROM is synchronous: present the PC that ID will hold next cycle.
  assign irom_addr  = fire ? pc_q : id_pc_q;
  assign id_pc_d    = fire ? pc_q : id_pc_q;
  assign if_valid_d = 1'b1;

  pc_next_mux u_pc_next_mux (
    .pc_i         (pc_q),
    .fire_i       (fire),
    .br_taken_i   (br_taken),
    .br_target_i  (br_target),
    .int_assert_i (int_assert),
    .int_addr_i   (int_addr),
    .pc_next_o    (pc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= RESET_PC;
      if_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

`ifdef IF_INT_TAG_EN
  logic int_tagged_q, int_tagged_d;

  assign int_flag = int_req & ~int_tagged_q;

  // Sticky until the trap is actually taken.
  always_comb begin
    int_tagged_d = int_tagged_q;
    if (int_assert)
      int_tagged_d = 1'b0;
    else if (fire & int_flag)
      int_tagged_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) int_tagged_q <= 1'b0;
    else     int_tagged_q <= int_tagged_d;
  end
`else
  logic unused_int_req;
  assign unused_int_req = int_req;
  assign int_flag       = 1'b0;
`endif

  assign bus_s.pc4      = pc_q + 32'd4;
  assign bus_s.pc       = pc_q;
  assign bus_s.int_flag = int_flag;
  assign if_to_id_bus   = bus_s;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_if_stage;

`ifdef IF_INT_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, br_taken, int_assert, int_req, hold_flag_if, id_allow_in;
  logic [31:0] br_target, int_addr;
  logic [31:0] irom_addr;
  logic [64:0] if_to_id_bus;
  logic        if_to_id_valid;

  logic        rst_w;
  logic [31:0] w_irom;
  logic [64:0] w_bus;
  logic        w_valid;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .int_assert     (int_assert),
    .int_addr       (int_addr),
    .int_req        (int_req),
    .hold_flag_if   (hold_flag_if),
    .id_allow_in    (id_allow_in),
    .irom_addr      (irom_addr),
    .if_to_id_bus   (if_to_id_bus),
    .if_to_id_valid (if_to_id_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk            (clk),
    .rst            (rst_w),
    .br_taken       (1'b0),
    .br_target      (32'h0),
    .int_assert     (1'b0),
    .int_addr       (32'h0),
    .int_req        (1'b0),
    .hold_flag_if   (1'b0),
    .id_allow_in    (1'b1),
    .irom_addr      (w_irom),
    .if_to_id_bus   (w_bus),
    .if_to_id_valid (w_valid)
  );

  typedef struct {
    logic        v;
    logic [31:0] irom;
    logic [64:0] bus;
  } cyc_t;

  cyc_t        cq[$];
  logic [64:0] tq[$];
  int          checks   = 0;
  int          failures = 0;

  // Reference model: address of the instruction on offer, address held by
  // ID, whether a fetch is live, and whether the pending interrupt was tagged.
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_idpc  = 32'h0;
  bit          m_live  = 1'b0;
  bit          m_tag   = 1'b0;

  task automatic chk(input string name, input logic [64:0] act,
                     input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit b, input logic [31:0] bt,
                     input bit ia, input logic [31:0] iad, input bit iq,
                     input bit h, input bit al);
    cyc_t  c;
    bit    v, f, flag;
    @(posedge clk);
    #1;
    rst = r; br_taken = b; br_target = bt; int_assert = ia;
    int_addr = iad; int_req = iq; hold_flag_if = h; id_allow_in = al;
    v    = m_live && !b && !ia && !h;
    f    = v && al;
    flag = TAG && iq && !m_tag;
    c.v    = v;
    c.irom = f ? m_pc : m_idpc;
    c.bus  = {m_pc + 32'd4, m_pc, flag};
    cq.push_back(c);
    if (f) tq.push_back(c.bus);
    if (r) begin
      m_pc = 32'h0; m_idpc = 32'h0; m_live = 1'b0; m_tag = 1'b0;
    end else begin
      m_live = 1'b1;
      if (f) m_idpc = m_pc;
      if (ia)      m_pc = iad & 32'hFFFF_FFFC;
      else if (b)  m_pc = bt & 32'hFFFF_FFFC;
      else if (f)  m_pc = m_pc + 32'd4;
      if (ia)             m_tag = 1'b0;
      else if (f && flag) m_tag = 1'b1;
    end
  endtask

  task automatic go(input int n, input bit iq, input bit al);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, iq, 0, al);
  endtask

  always @(negedge clk) begin
    cyc_t c;
    if (cq.size() > 0) begin
      c = cq.pop_front();
      chk("valid", {64'h0, if_to_id_valid}, {64'h0, c.v});
      chk("irom_addr", {33'h0, irom_addr}, {33'h0, c.irom});
      chk("bus", if_to_id_bus, c.bus);
      if (if_to_id_valid && id_allow_in) begin
        if (tq.size() == 0) begin
          checks++; failures++;
          $display("FAIL fire_unexpected actual=%h required=none",
                   if_to_id_bus);
        end else begin
          chk("fire_txn", if_to_id_bus, tq.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rst_w = 1'b1; br_taken = 0; br_target = 0; int_assert = 0;
    int_addr = 0; int_req = 0; hold_flag_if = 0; id_allow_in = 1;

    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("reset_bus", if_to_id_bus, {32'h4, 32'h0, 1'b0});
    chk("reset_valid", {64'h0, if_to_id_valid}, 65'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    go(4, 0, 1);
    go(3, 0, 0);
    #1;
    chk("stall_irom", {33'h0, irom_addr}, {33'h0, 32'hC});
    chk("stall_pc", {33'h0, if_to_id_bus[32:1]}, {33'h0, 32'h10});
    go(4, 0, 1);
    cyc(0, 1, 32'h102, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("branch_pc", {33'h0, if_to_id_bus[32:1]}, {33'h0, 32'h100});
    chk("branch_valid", {64'h0, if_to_id_valid}, 65'h1);
    cyc(0, 1, 32'h100, 1, 32'h200, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    chk("collide_pc", {33'h0, if_to_id_bus[32:1]}, {33'h0, 32'h200});
    chk("collide_valid", {64'h0, if_to_id_valid}, 65'h0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    go(2, 0, 1);
    go(3, 1, 1);
    cyc(0, 0, 0, 1, 32'h300, 1, 0, 1);
    #1;
    chk("int_redirect_valid", {64'h0, if_to_id_valid}, 65'h0);
    go(3, 1, 1);
    cyc(0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 1);
    go(3, 0, 1);

    for (int i = 0; i < 400; i++) begin
      bit          r, b, ia, iq, h, al;
      logic [31:0] bt, iad;
      r  = ($urandom % 60) == 0;
      b  = ($urandom % 6) == 0;
      bt = ($urandom % 4 == 0) ? 32'hFFFF_FFFC : $urandom;
      ia = ($urandom % 15) == 0;
      iad = $urandom;
      iq = ($urandom % 3) != 0;
      h  = ($urandom % 5) == 0;
      al = ($urandom % 4) != 0;
      cyc(r, b, bt, ia, iad, iq, h, al);
    end
    go(2, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("cycle_queue_drained", {33'h0, 32'(cq.size())}, 65'h0);
    chk("txn_queue_drained", {33'h0, 32'(tq.size())}, 65'h0);

    #1;
    chk("wrap_reset_irom", {33'h0, w_irom}, {33'h0, 32'hFFFF_FFFC});
    chk("wrap_reset_bus", w_bus, {32'h0, 32'hFFFF_FFFC, 1'b0});
    @(posedge clk); #1; rst_w = 1'b0;
    @(posedge clk); #2;
    chk("wrap_fire_valid", {64'h0, w_valid}, 65'h1);
    chk("wrap_fire_bus", w_bus, {32'h0, 32'hFFFF_FFFC, 1'b0});
    chk("wrap_fire_irom", {33'h0, w_irom}, {33'h0, 32'hFFFF_FFFC});
    @(posedge clk); #2;
    chk("wrap_next_bus", w_bus, {32'h4, 32'h0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
